ctrl_pipeline: RTL
==================

# ctrl_pipeline

Carries the 26-bit control bundle produced by the decode-stage control unit through the EX, MEM and WB pipeline registers. It resolves the bundle's stall bit, branch/jump flushes and data-memory wait states into bubbles and holds, and computes the destination register per stage. It drives the PC and IF/ID write enables and exports stage destinations for forwarding. It also keeps a saturating stall-cycle counter for performance measurement.

## Interface
- No parameters; bundle width fixed at 26, register index width fixed at 5.
- clk  input  1  pipeline clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- bundle_in  input  26  decode control bundle: [0] regfile_we, [1] wrdata_mux, [2] mem_re, [3] mem_we, [5:4] mem_size, [6] signed, [7] data_mem_mux, [13:8] alu_func, [15:14] dest select, [16] shift_mux, [17] alu_mux, [18] lui_mux, [19] ext_mux, [23:20] jump/branch muxes, [24] pc_enable, [25] nop_stall
- instr_in  input  32  ID-stage instruction word, for dest fields
- flush_in  input  1  branch/jump taken in EX; kill the ID instruction
- mem_wait_in  input  1  data memory not ready; freeze pipeline
- clear_count_in  input  1  synchronous clear of stall_count_out
- ex_bundle_out  output  26  registered EX-stage bundle, bit 25 always 0
- mem_bundle_out  output  8  registered MEM-stage bundle bits [7:0]
- wb_bundle_out  output  2  registered WB-stage bundle bits [1:0]
- ex_dest_out, mem_dest_out, wb_dest_out  output  5 each  destination register per stage
- wb_we_out  output  1  register-file write enable
- pc_enable_out  output  1  PC update enable (combinational)
- ifid_we_out  output  1  IF/ID register write enable (combinational)
- stall_count_out  output  16  saturating count of frozen/stalled cycles

## Operation
- Dest decode from bundle_in[15:14]: 00 -> instr_in[20:16], 01 -> instr_in[15:11], 10 -> 5'd31, 11 -> 5'd0.
- Bubble: all bundle bits 0, dest 0.
- Per-cycle action, priority highest first:
  - mem_wait_in=1: HOLD. EX, MEM and WB keep their values. pc_enable_out=0, ifid_we_out=0.
  - flush_in=1: EX<-bubble, MEM<-EX, WB<-MEM. pc_enable_out=1, ifid_we_out=1. The ID instruction is discarded, so any stall on it is ignored.
  - bundle_in[25]=1: STALL. EX<-bubble, MEM<-EX, WB<-MEM. pc_enable_out=0, ifid_we_out=0.
  - Otherwise: ADVANCE. EX<-{1'b0, bundle_in[24:0]} with its dest, MEM<-EX[7:0] and dest, WB<-MEM[1:0] and dest. pc_enable_out=bundle_in[24], ifid_we_out=1.
- wb_we_out = wb_bundle_out[0] & (wb_dest_out != 0). Writes to $0 are suppressed.
- A flush arriving during HOLD is not lost. The branch stays in EX, so its source keeps flush_in asserted until the cycle after mem_wait_in drops.
- stall_count_out:
  - Increments by 1 in any cycle with HOLD or STALL.
  - Saturates at 16'hFFFF.
  - clear_count_in loads 0 and wins over increment.

## Timing
- Reset (async assert, sync-safe release): all stage registers, dests and stall_count_out go to 0; wb_we_out=0.
- pc_enable_out and ifid_we_out are combinational from bundle_in, flush_in and mem_wait_in. Their values are not reset-dependent.
- Latency: a bundle presented in cycle N (ADVANCE) reaches EX at N+1, MEM at N+2 and WB at N+3, provided no HOLD intervenes. Each HOLD cycle adds exactly one cycle at every stage.
- Reset asserted mid-operation drops all in-flight stages immediately. The first post-reset edge loads EX from bundle_in normally.
- No combinational path from flush_in or mem_wait_in to the stage outputs; the stage outputs are register outputs only.

## Test plan
- Reset then ADVANCE: add $3,$1,$2 (bundle[15:14]=01, [0]=1), then bubbles. ex_dest_out=3 at N+1 and mem_dest_out=3 at N+2. At N+3, wb_dest_out=3 and wb_we_out=1.
- Dest and $0 suppression:
  - jal (select 10) gives wb_dest_out=31 and wb_we_out=1.
  - addi with rt=0 gives wb_dest_out=0 and wb_we_out=0.
  - lw with rt=7 gives ex_dest_out=7 and mem_bundle_out[2]=1.
- Stall: bundle_in[25]=1 for 2 cycles behind a load. pc_enable_out=0 and ifid_we_out=0 in both cycles, and two bubbles enter EX. The load advances to WB on schedule, and stall_count_out increments by 2.
- HOLD: mem_wait_in=1 for 3 cycles with a sw in MEM. mem_bundle_out[3] stays 1 and all three stages stay unchanged. stall_count_out increments by 3, and the pipeline resumes with WB receiving the sw one cycle after mem_wait_in drops.
- Simultaneous events:
  - flush_in=1 with bundle_in[25]=1: EX<-bubble, pc_enable_out=1, ifid_we_out=1, no count increment.
  - flush_in=1 with mem_wait_in=1: HOLD, flush has no effect that cycle.
- Counter: force 16'hFFFE, then stall for 3 cycles. The counter reads FFFF and stays there. Assert clear_count_in together with a stall: the counter reads 0 next cycle.

Source files
------------

// File: rtl/ctrl_pipeline.sv
// Control-bundle pipeline: carries the decode bundle through EX/MEM/WB, applies stall,
// flush and memory-wait policy, and keeps a saturating stall-cycle counter.
module ctrl_pipeline (
  input  logic        clk,
  input  logic        reset,
  input  logic [25:0] bundle_in,
  input  logic [31:0] instr_in,
  input  logic        flush_in,
  input  logic        mem_wait_in,
  input  logic        clear_count_in,
  output logic [25:0] ex_bundle_out,
  output logic [7:0]  mem_bundle_out,
  output logic [1:0]  wb_bundle_out,
  output logic [4:0]  ex_dest_out,
  output logic [4:0]  mem_dest_out,
  output logic [4:0]  wb_dest_out,
  output logic        wb_we_out,
  output logic        pc_enable_out,
  output logic        ifid_we_out,
  output logic [15:0] stall_count_out
);

  typedef enum logic [1:0] {
    ActAdvance,
    ActStall,
    ActFlush,
    ActHold
  } action_e;

  localparam logic [15:0] CountMax = 16'hFFFF;

  logic [25:0] ex_bundle_q, ex_bundle_d;
  logic [7:0]  mem_bundle_q, mem_bundle_d;
  logic [1:0]  wb_bundle_q, wb_bundle_d;
  logic [4:0]  ex_dest_q, ex_dest_d;
  logic [4:0]  mem_dest_q, mem_dest_d;
  logic [4:0]  wb_dest_q, wb_dest_d;
  logic [15:0] stall_count_q, stall_count_d;

  action_e     action;
  logic [4:0]  id_dest;

  // Priority: memory wait freezes everything, then flush (which discards the ID stall).
  always_comb begin
    action = ActAdvance;
    if (mem_wait_in) begin
      action = ActHold;
    end else if (flush_in) begin
      action = ActFlush;
    end else if (bundle_in[25]) begin
      action = ActStall;
    end
  end

  always_comb begin
    id_dest = 5'd0;
    unique case (bundle_in[15:14])
      2'b00: id_dest = instr_in[20:16];
      2'b01: id_dest = instr_in[15:11];
      2'b10: id_dest = 5'd31;
      2'b11: id_dest = 5'd0;
      default: id_dest = 5'd0;
    endcase
  end

  always_comb begin
    pc_enable_out = 1'b0;
    ifid_we_out   = 1'b0;
    unique case (action)
      ActHold: begin
        pc_enable_out = 1'b0;
        ifid_we_out   = 1'b0;
      end
      ActFlush: begin
        pc_enable_out = 1'b1;
        ifid_we_out   = 1'b1;
      end
      ActStall: begin
        pc_enable_out = 1'b0;
        ifid_we_out   = 1'b0;
      end
      ActAdvance: begin
        pc_enable_out = bundle_in[24];
        ifid_we_out   = 1'b1;
      end
      default: begin
        pc_enable_out = 1'b0;
        ifid_we_out   = 1'b0;
      end
    endcase
  end

  always_comb begin
    ex_bundle_d  = ex_bundle_q;
    ex_dest_d    = ex_dest_q;
    mem_bundle_d = mem_bundle_q;
    mem_dest_d   = mem_dest_q;
    wb_bundle_d  = wb_bundle_q;
    wb_dest_d    = wb_dest_q;
    if (action != ActHold) begin
      mem_bundle_d = ex_bundle_q[7:0];
      mem_dest_d   = ex_dest_q;
      wb_bundle_d  = mem_bundle_q[1:0];
      wb_dest_d    = mem_dest_q;
      if (action == ActAdvance) begin
        ex_bundle_d = {1'b0, bundle_in[24:0]};
        ex_dest_d   = id_dest;
      end else begin
        ex_bundle_d = 26'd0;
        ex_dest_d   = 5'd0;
      end
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (clear_count_in) begin
      stall_count_d = 16'd0;
    end else if ((action == ActHold || action == ActStall) && stall_count_q != CountMax) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_bundle_q   <= 26'd0;
      ex_dest_q     <= 5'd0;
      mem_bundle_q  <= 8'd0;
      mem_dest_q    <= 5'd0;
      wb_bundle_q   <= 2'd0;
      wb_dest_q     <= 5'd0;
      stall_count_q <= 16'd0;
    end else begin
      ex_bundle_q   <= ex_bundle_d;
      ex_dest_q     <= ex_dest_d;
      mem_bundle_q  <= mem_bundle_d;
      mem_dest_q    <= mem_dest_d;
      wb_bundle_q   <= wb_bundle_d;
      wb_dest_q     <= wb_dest_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign ex_bundle_out   = ex_bundle_q;
  assign mem_bundle_out  = mem_bundle_q;
  assign wb_bundle_out   = wb_bundle_q;
  assign ex_dest_out     = ex_dest_q;
  assign mem_dest_out    = mem_dest_q;
  assign wb_dest_out     = wb_dest_q;
  assign wb_we_out       = wb_bundle_q[0] & (wb_dest_q != 5'd0);
  assign stall_count_out = stall_count_q;

endmodule
